// File: rtl/btn_pkg.sv
// Shared constants for the front-panel button conditioner.
//   NUM_BTN          : number of conditioned buttons
//   BTN_*            : bit index of each button in btn_raw / btn_level / pulse vectors
//   DEFAULT_*_CYCLES : default debounce and long-press timings at 100 MHz
package btn_pkg;

    localparam int unsigned NUM_BTN   = 5;

    localparam int unsigned BTN_ONOFF = 0;
    localparam int unsigned BTN_MENU  = 1;
    localparam int unsigned BTN_MODE1 = 2;
    localparam int unsigned BTN_MODE2 = 3;
    localparam int unsigned BTN_MODE3 = 4;

    // 20 ms debounce, 3 s long press at 100 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 2_000_000;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 300_000_000;

endpackage

// File: rtl/debounce_cell.sv
// Single-bit button conditioner: 2-flop synchronizer, persistence counter,
// debounced level and registered edge pulses.
//   clk           : system clock
//   rst           : asynchronous active-low reset
//   raw           : raw button input, asynchronous to clk
//   level         : debounced level
//   press_pulse   : one-cycle pulse in the first cycle level reads 1
//   release_pulse : one-cycle pulse in the first cycle level reads 0
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = btn_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          raw_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          differ;
    logic          done;

    assign raw_s = sync_q[1];

    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        differ    = (raw_s != level_q);
        // New level has been seen for DEBOUNCE_CYCLES consecutive samples.
        done      = differ && (cnt_q == CNT_LAST);
        if (done) begin
            level_d   = raw_s;
            press_d   = raw_s;
            release_d = !raw_s;
        end else if (differ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: debounces NUM_BTN raw buttons and derives
// long/short press events for the on/off button.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   btn_raw     : raw active-high buttons (asynchronous)
//   btn_level   : debounced levels
//   btn_press   : one-cycle pulses on debounced 0->1
//   btn_release : one-cycle pulses on debounced 1->0
//   power_long  : one-cycle pulse once on/off has been held LONG_CYCLES
//   power_short : one-cycle pulse on on/off release when no long press fired
//   activity    : OR of btn_press
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               power_long,
    output logic               power_short,
    output logic               activity
);

    localparam int unsigned LW = $clog2(LONG_CYCLES) + 1;
    localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .raw          (btn_raw[i]),
            .level        (btn_level[i]),
            .press_pulse  (btn_press[i]),
            .release_pulse(btn_release[i])
        );
    end

    logic [LW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d;
    logic          onoff;

    assign onoff = btn_level[BTN_ONOFF];

    always_comb begin
        hold_d  = '0;
        fired_d = 1'b0;
        // Saturating hold counter keeps power_long from re-firing on very long holds.
        if (onoff) begin
            hold_d  = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
            fired_d = fired_q || power_long;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
        end
    end

    // fired_q still holds the finished hold's state in the release cycle:
    // it only clears on the edge after btn_level[0] drops.
    assign power_long  = onoff && (hold_q == HOLD_LAST) && !fired_q;
    assign power_short = btn_release[BTN_ONOFF] && !fired_q;
    assign activity    = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic       power_long;
    logic       power_short;
    logic       activity;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int press_n   [5];
    int release_n [5];
    int press_at  [5];
    int release_at[5];
    int long_n, short_n, act_n, both_n;
    int long_at, short_at;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .power_long (power_long),
        .power_short(power_short),
        .activity   (activity)
    );

    task automatic clear_counts();
        for (int i = 0; i < 5; i++) begin
            press_n[i] = 0; release_n[i] = 0; press_at[i] = -1; release_at[i] = -1;
        end
        long_n = 0; short_n = 0; act_n = 0; both_n = 0; long_at = -1; short_at = -1;
    endtask

    // Advance one clock and log every pulse seen just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 5; i++) begin
            if (btn_press[i])   begin press_n[i]++;   press_at[i]   = cyc; end
            if (btn_release[i]) begin release_n[i]++; release_at[i] = cyc; end
        end
        if (power_long)  begin long_n++;  long_at  = cyc; end
        if (power_short) begin short_n++; short_at = cyc; end
        if (power_long && power_short) both_n++;
        if (activity) act_n++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn_raw = 5'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, power_long, power_short, activity} !== 18'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {btn_level, btn_press, btn_release, power_long, power_short, activity});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({btn_level, btn_press, btn_release, power_long, power_short, activity} !== 18'b0) begin
            errors++;
            $display("FAIL first_cycle_after_reset got=%h want=0",
                     {btn_level, btn_press, btn_release, power_long, power_short, activity});
        end
    endtask

    task automatic test_clean_press();
        int start;
        clear_counts();
        btn_raw[1] = 1'b1;
        start = cyc;
        for (int k = 1; k <= 2 + D; k++) begin
            tick();
            checks++;
            if (btn_level[1] !== (k == 2 + D)) begin
                errors++;
                $display("FAIL clean_level k=%0d got=%b want=%b", k, btn_level[1], k == 2 + D);
            end
        end
        repeat (5) tick();
        checks++;
        if (press_n[1] !== 1 || press_at[1] !== start + 6) begin
            errors++;
            $display("FAIL clean_press got n=%0d at=%0d want n=1 at=%0d",
                     press_n[1], press_at[1] - start, 6);
        end
        checks++;
        if (act_n !== 1 || press_n[0] + press_n[2] + press_n[3] + press_n[4] !== 0 ||
            long_n + short_n !== 0) begin
            errors++;
            $display("FAIL clean_other_pulses got act=%0d long=%0d short=%0d want act=1 others=0",
                     act_n, long_n, short_n);
        end
        btn_raw[1] = 1'b0;
        start = cyc;
        repeat (10) tick();
        checks++;
        if (release_n[1] !== 1 || release_at[1] !== start + 6 || btn_level[1] !== 1'b0) begin
            errors++;
            $display("FAIL clean_release got n=%0d at=%0d lvl=%b want n=1 at=6 lvl=0",
                     release_n[1], release_at[1] - start, btn_level[1]);
        end
    endtask

    task automatic test_bounce();
        int start;
        clear_counts();
        btn_raw[2] = 1'b1;
        repeat (3) tick();
        btn_raw[2] = 1'b0;
        tick();
        btn_raw[2] = 1'b1;
        start = cyc;
        repeat (12) tick();
        checks++;
        if (press_n[2] !== 1 || press_at[2] !== start + 6) begin
            errors++;
            $display("FAIL bounce_press got n=%0d at=%0d want n=1 at=6",
                     press_n[2], press_at[2] - start);
        end
        checks++;
        if (release_n[2] !== 0) begin
            errors++;
            $display("FAIL bounce_release got n=%0d want 0", release_n[2]);
        end
        btn_raw[2] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_short_power();
        int start;
        clear_counts();
        btn_raw[0] = 1'b1;
        start = cyc;
        repeat (10) tick();
        btn_raw[0] = 1'b0;
        repeat (20) tick();
        checks++;
        if (press_n[0] !== 1 || press_at[0] !== start + 6) begin
            errors++;
            $display("FAIL short_press got n=%0d at=%0d want n=1 at=6",
                     press_n[0], press_at[0] - start);
        end
        checks++;
        if (release_n[0] !== 1 || release_at[0] !== start + 16) begin
            errors++;
            $display("FAIL short_release got n=%0d at=%0d want n=1 at=16",
                     release_n[0], release_at[0] - start);
        end
        checks++;
        if (short_n !== 1 || short_at !== start + 16 || long_n !== 0) begin
            errors++;
            $display("FAIL short_power got short=%0d at=%0d long=%0d want short=1 at=16 long=0",
                     short_n, short_at - start, long_n);
        end
    endtask

    task automatic test_long_power();
        int start;
        clear_counts();
        btn_raw[0] = 1'b1;
        start = cyc;
        repeat (40) tick();
        btn_raw[0] = 1'b0;
        repeat (15) tick();
        checks++;
        if (long_n !== 1 || long_at !== press_at[0] + 19 || press_at[0] !== start + 6) begin
            errors++;
            $display("FAIL long_power got n=%0d at=%0d press_at=%0d want n=1 at=25 press_at=6",
                     long_n, long_at - start, press_at[0] - start);
        end
        checks++;
        if (release_n[0] !== 1 || release_at[0] !== start + 46 || short_n !== 0 || both_n !== 0)
        begin
            errors++;
            $display("FAIL long_release got rel=%0d at=%0d short=%0d want rel=1 at=46 short=0",
                     release_n[0], release_at[0] - start, short_n);
        end
    endtask

    task automatic test_simultaneous();
        int start;
        clear_counts();
        btn_raw[4:3] = 2'b11;
        start = cyc;
        repeat (10) tick();
        checks++;
        if (press_n[3] !== 1 || press_n[4] !== 1 || press_at[3] !== start + 6 ||
            press_at[4] !== start + 6) begin
            errors++;
            $display("FAIL simul_press got at3=%0d at4=%0d want 6 6",
                     press_at[3] - start, press_at[4] - start);
        end
        checks++;
        if (act_n !== 1) begin
            errors++;
            $display("FAIL simul_activity got %0d want 1", act_n);
        end
        btn_raw[4:3] = 2'b00;
        start = cyc;
        repeat (10) tick();
        checks++;
        if (release_at[3] !== start + 6 || release_at[4] !== start + 6 || act_n !== 1) begin
            errors++;
            $display("FAIL simul_release got at3=%0d at4=%0d act=%0d want 6 6 1",
                     release_at[3] - start, release_at[4] - start, act_n);
        end
    endtask

    task automatic test_reset_mid_hold();
        int start;
        clear_counts();
        btn_raw[0] = 1'b1;
        start = cyc;
        repeat (21) tick();
        checks++;
        if (dut.hold_q !== 5'd15 || btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL midhold_setup got hold=%0d lvl=%b want 15 1", dut.hold_q, btn_level[0]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, power_long, power_short, activity} !== 18'b0) begin
            errors++;
            $display("FAIL midhold_async_clear got=%h want=0",
                     {btn_level, btn_press, btn_release, power_long, power_short, activity});
        end
        repeat (2) tick();
        checks++;
        if ({btn_level, btn_press, btn_release, power_long, power_short, activity} !== 18'b0) begin
            errors++;
            $display("FAIL midhold_in_reset got=%h want=0",
                     {btn_level, btn_press, btn_release, power_long, power_short, activity});
        end
        clear_counts();
        rst = 1'b1;
        start = cyc;
        tick();
        checks++;
        if ({btn_press, btn_release, power_long, power_short, activity} !== 13'b0) begin
            errors++;
            $display("FAIL midhold_first_cycle got=%h want=0",
                     {btn_press, btn_release, power_long, power_short, activity});
        end
        repeat (34) tick();
        checks++;
        if (press_n[0] !== 1 || press_at[0] !== start + 6) begin
            errors++;
            $display("FAIL midhold_press got n=%0d at=%0d want n=1 at=6",
                     press_n[0], press_at[0] - start);
        end
        checks++;
        if (long_n !== 1 || long_at !== start + 25) begin
            errors++;
            $display("FAIL midhold_long got n=%0d at=%0d want n=1 at=25", long_n, long_at - start);
        end
        btn_raw[0] = 1'b0;
        repeat (10) tick();
        checks++;
        if (release_n[0] !== 1 || short_n !== 0) begin
            errors++;
            $display("FAIL midhold_release got rel=%0d short=%0d want 1 0", release_n[0], short_n);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_power();
        test_long_power();
        test_simultaneous();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 2_000_000, consecutive synchronized cycles a new level must persist (20 ms at 100 MHz).
REQ-002 Parameter: LONG_CYCLES, default 300_000_000, hold time on btn index 0 that qualifies as a long press (3 s at 100 MHz).
REQ-003 Port: clk  input  1  system clock; all logic on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: btn_raw  input  5  raw active-high buttons, bit0 on_off, bit1 menu, bit2 mode1, bit3 mode2, bit4 mode3; asynchronous to clk.
REQ-006 Port: btn_level  output  5  debounced stable level per button.
REQ-007 Port: btn_press  output  5  one-cycle pulse per button on debounced 0->1.
REQ-008 Port: btn_release  output  5  one-cycle pulse per button on debounced 1->0.
REQ-009 Port: power_long  output  1  one-cycle pulse when bit0 has been held LONG_CYCLES.
REQ-010 Port: power_short  output  1  one-cycle pulse on bit0 release if power_long did not fire during that hold.
REQ-011 Port: activity  output  1  one-cycle pulse when any btn_press bit is set (OR of btn_press).

Function
REQ-012 Each btn_raw bit SHALL pass a 2-flop synchronizer; debounce acts only on the second-flop output (raw_s).
REQ-013 Per button: raw_s == btn_level SHALL clear the debounce counter; raw_s != btn_level SHALL increment it.
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and raw_s still differs, btn_level SHALL take raw_s on the next edge and the counter SHALL clear.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave btn_level, btn_press and btn_release unchanged.
REQ-016 Latency: a clean raw edge SHALL appear on btn_level exactly 2 + DEBOUNCE_CYCLES clk edges later.
REQ-017 btn_press[i] / btn_release[i] SHALL be registered and high exactly in the first cycle btn_level[i] shows its new value.
REQ-018 Buttons SHALL be fully independent; simultaneous transitions on several bits SHALL produce simultaneous pulses.
REQ-019 Hold counter for bit0: clears while btn_level[0]=0, increments while 1, saturates at LONG_CYCLES.
REQ-020 power_long SHALL pulse in the cycle the hold counter reaches LONG_CYCLES-1; at most once per hold.
REQ-021 power_short and btn_release[0] SHALL pulse in the same cycle; power_short only if power_long has not fired in that hold.
REQ-022 power_short and power_long SHALL never both pulse for one hold.
REQ-023 Counter widths SHALL be $clog2 of the respective parameter + 1; no wrap-around permitted.

Reset
REQ-024 rst low SHALL immediately clear synchronizers, counters, btn_level, all pulse outputs and the long-fired flag to 0.
REQ-025 A button held through reset release SHALL be treated as a new press: btn_press after 2 + DEBOUNCE_CYCLES cycles, hold timing restarting from then.
REQ-026 No output SHALL pulse in the first cycle after reset deassertion.

Structure
REQ-027 Shared package btn_pkg SHALL hold NUM_BTN=5, the index constants BTN_ONOFF=0, BTN_MENU=1, BTN_MODE1=2, BTN_MODE2=3, BTN_MODE3=4, and the default cycle counts.
REQ-028 One sub-module debounce_cell (synchronizer, counter, level, press/release for one bit) SHALL be instantiated NUM_BTN times.
REQ-029 Long/short-press logic SHALL stay in button_conditioner; debounce_cell SHALL be purely parameterized by DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-030 Clean press: btn_raw[1] 0->1 held -> btn_level[1]=1 and btn_press[1] pulse exactly 6 edges later, no other pulses.
REQ-031 Bounce: btn_raw[2] toggled high 3 cycles, low 1, high steady -> exactly one btn_press[2], 6 edges after the final rise.
REQ-032 Short power: btn_raw[0] high 10 cycles then low -> btn_press[0], then btn_release[0] together with power_short; power_long never.
REQ-033 Long power: btn_raw[0] high 40 cycles -> power_long once, 19 edges after btn_press[0]; on release btn_release[0] without power_short.
REQ-034 Simultaneous: btn_raw[4:3] rise on the same edge -> btn_press[3] and btn_press[4] in the same cycle, activity pulses once.
REQ-035 Reset mid-hold: rst low for 2 cycles while btn_raw[0] high at hold count 15 -> all outputs 0; after release, btn_press[0] 6 edges later, power_long 19 edges after that.
